cache_replace_ctrl: RTL and testbench

// Miss/replacement controller for the 4-way set-associative L1 cache. It sits between the
// CPU memory port, the per-set LRU tracker and physical memory.
// - Initiator side of the LRU interface: consumes lru_way, drives lru_write/lru_index.
// - Picks victims, sequences dirty write-back and line fill, and returns mem_resp to the CPU.

---
 rtl/cache_replace_ctrl_pkg.sv | 22 ++
 rtl/cache_replace_ctrl_victim_select.sv | 22 ++
 rtl/cache_replace_ctrl.sv | 121 ++++++++++++
 tb/tb_cache_replace_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cache_replace_ctrl_pkg.sv
// Shared types for the L1 miss/replacement controller.
package cache_replace_ctrl_pkg;

  localparam int NUM_WAYS = 4;
  localparam int WAY_W    = $clog2(NUM_WAYS);

  typedef logic [1:0] lc3b_way;
  typedef logic [3:0] lc3b_way_mask;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FETCH     = 2'd3
  } cache_state_t;

  // True when at least one way of the set is still unused.
  function automatic logic has_invalid(input lc3b_way_mask valid);
    return ~&valid;
  endfunction

endpackage

// File: rtl/cache_replace_ctrl_victim_select.sv
// Victim picker: the lowest-index invalid way wins; when the set is full,
// the LRU way is evicted.
module cache_replace_ctrl_victim_select
  import cache_replace_ctrl_pkg::*;
(
  input  lc3b_way_mask way_valid,
  input  lc3b_way      lru_way,
  output lc3b_way      victim
);

  // Priority encode the first free way, otherwise fall back to LRU.
  always_comb begin
    victim = lru_way;
    if (has_invalid(way_valid)) begin
      if (!way_valid[0])      victim = 2'd0;
      else if (!way_valid[1]) victim = 2'd1;
      else if (!way_valid[2]) victim = 2'd2;
      else                    victim = 2'd3;
    end
  end

endmodule

// File: rtl/cache_replace_ctrl.sv
// Miss/replacement controller for the 4-way L1: hit handling with LRU
// promotion, victim selection, dirty write-back and line fill.
module cache_replace_ctrl
  import cache_replace_ctrl_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic                hit,
  input  logic [WAY_W-1:0]    hit_way,
  input  logic [NUM_WAYS-1:0] way_valid,
  input  logic [NUM_WAYS-1:0] way_dirty,
  input  logic [WAY_W-1:0]    lru_way,
  output logic                lru_write,
  output logic [WAY_W-1:0]    lru_index,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  output logic                pmem_addr_sel,
  output logic                fill_we,
  output logic [WAY_W-1:0]    fill_way,
  output logic                data_we,
  output logic                dirty_set,
  output logic                dirty_clr
);

  cache_state_t state, next_state;
  lc3b_way      victim_q, victim_d, victim_c;
  logic         req;

  assign req = mem_read | mem_write;

  cache_replace_ctrl_victim_select u_victim_select (
    .way_valid (way_valid),
    .lru_way   (lru_way),
    .victim    (victim_c)
  );

  // State and victim registers; reset drops any in-flight memory transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      victim_q <= '0;
    end else begin
      state    <= next_state;
      victim_q <= victim_d;
    end
  end

  // Next-state and state-decoded outputs, qualified by the current inputs.
  always_comb begin
    next_state    = state;
    victim_d      = victim_q;
    mem_resp      = 1'b0;
    lru_write     = 1'b0;
    lru_index     = '0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    fill_we       = 1'b0;
    fill_way      = '0;
    data_we       = 1'b0;
    dirty_set     = 1'b0;
    dirty_clr     = 1'b0;

    unique case (state)
      IDLE: begin
        if (req) next_state = CHECK;
      end

      CHECK: begin
        if (!req) begin
          // CPU walked away; return silently without touching LRU state.
          next_state = IDLE;
        end else if (hit) begin
          mem_resp   = 1'b1;
          lru_write  = 1'b1;
          lru_index  = hit_way;
          // Simultaneous read and write is resolved as a write.
          if (mem_write) begin
            data_we   = 1'b1;
            dirty_set = 1'b1;
          end
          next_state = IDLE;
        end else begin
          // Victim is latched and the write-back decision made this cycle.
          victim_d = victim_c;
          if (way_valid[victim_c] && way_dirty[victim_c]) next_state = WRITEBACK;
          else                                            next_state = FETCH;
        end
      end

      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        fill_way      = victim_q;
        if (pmem_resp) begin
          dirty_clr  = 1'b1;
          next_state = FETCH;
        end
      end

      FETCH: begin
        pmem_read = 1'b1;
        fill_way  = victim_q;
        if (pmem_resp) begin
          fill_we    = 1'b1;
          next_state = CHECK;
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_replace_ctrl.sv
// Directed bench for cache_replace_ctrl with hand-computed expected outputs.
module tb_cache_replace_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, mem_write, mem_resp;
  logic       hit;
  logic [1:0] hit_way;
  logic [3:0] way_valid, way_dirty;
  logic [1:0] lru_way;
  logic       lru_write;
  logic [1:0] lru_index;
  logic       pmem_read, pmem_write, pmem_resp, pmem_addr_sel;
  logic       fill_we;
  logic [1:0] fill_way;
  logic       data_we, dirty_set, dirty_clr;

  int passes = 0;
  int checks = 0;
  int cyc    = 0;
  int start;

  always #5 clk = ~clk;

  cache_replace_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_resp      (mem_resp),
    .hit           (hit),
    .hit_way       (hit_way),
    .way_valid     (way_valid),
    .way_dirty     (way_dirty),
    .lru_way       (lru_way),
    .lru_write     (lru_write),
    .lru_index     (lru_index),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_resp     (pmem_resp),
    .pmem_addr_sel (pmem_addr_sel),
    .fill_we       (fill_we),
    .fill_way      (fill_way),
    .data_we       (data_we),
    .dirty_set     (dirty_set),
    .dirty_clr     (dirty_clr)
  );

  // Output vector: resp,lw,li[2],pr,pw,sel,fwe,fw[2],dwe,dset,dclr
  logic [12:0] obs;
  assign obs = {mem_resp, lru_write, lru_index, pmem_read, pmem_write, pmem_addr_sel,
                fill_we, fill_way, data_we, dirty_set, dirty_clr};

  function automatic logic [12:0] ex(input logic resp, input logic lw, input logic [1:0] li,
                                     input logic pr, input logic pw, input logic sel,
                                     input logic fwe, input logic [1:0] fw,
                                     input logic dwe, input logic dset, input logic dclr);
    return {resp, lw, li, pr, pw, sel, fwe, fw, dwe, dset, dclr};
  endfunction

  localparam logic [12:0] ZERO = 13'd0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [12:0] e);
    #1;
    checks++;
    assert (obs === e) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, e);
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
  endtask

  initial begin
    rst = 1'b1; mem_read = 0; mem_write = 0; hit = 0; hit_way = 0;
    way_valid = 4'b0000; way_dirty = 4'b0000; lru_way = 0; pmem_resp = 0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_idle", ZERO);

    // Read hit on way 2: response in cycle 2.
    mem_read = 1; hit = 1; hit_way = 2'd2;
    chk("rd_hit_c1", ZERO);
    tick();
    chk("rd_hit_c2", ex(1,1,2'd2,0,0,0,0,2'd0,0,0,0));
    tick();
    mem_read = 0; hit = 0;
    chk("rd_hit_idle", ZERO);

    // Write hit on way 1.
    mem_write = 1; hit = 1; hit_way = 2'd1;
    tick();
    chk("wr_hit", ex(1,1,2'd1,0,0,0,0,2'd0,1,1,0));
    tick();
    mem_write = 0; hit = 0;

    // Clean miss, way 2 free, F=5; mem_resp at cycle 8.
    way_valid = 4'b1011; way_dirty = 4'b0000; lru_way = 2'd0; mem_read = 1;
    start = cyc;
    tick();
    chk("cm_check", ZERO);
    tick();
    chk("cm_fetch1", ex(0,0,2'd0,1,0,0,0,2'd2,0,0,0));
    tick(); tick(); tick();
    chk("cm_fetch4", ex(0,0,2'd0,1,0,0,0,2'd2,0,0,0));
    tick();
    pmem_resp = 1;
    chk("cm_fill", ex(0,0,2'd0,1,0,0,1,2'd2,0,0,0));
    tick();
    pmem_resp = 0; hit = 1; hit_way = 2'd2;
    chk("cm_rehit", ex(1,1,2'd2,0,0,0,0,2'd0,0,0,0));
    chk_int("cm_latency", cyc - start + 1, 8);
    tick();
    mem_read = 0; hit = 0;

    // Dirty miss: all valid, way 2 dirty and LRU; LRU flips mid-miss.
    way_valid = 4'b1111; way_dirty = 4'b0100; lru_way = 2'd2; mem_write = 1;
    tick();
    tick();
    chk("dm_wb", ex(0,0,2'd0,0,1,1,0,2'd2,0,0,0));
    lru_way = 2'd3;
    tick();
    chk("dm_wb_lru_flip", ex(0,0,2'd0,0,1,1,0,2'd2,0,0,0));
    pmem_resp = 1;
    chk("dm_wb_done", ex(0,0,2'd0,0,1,1,0,2'd2,0,0,1));
    tick();
    pmem_resp = 0;
    chk("dm_fetch", ex(0,0,2'd0,1,0,0,0,2'd2,0,0,0));
    tick();
    pmem_resp = 1;
    chk("dm_fill", ex(0,0,2'd0,1,0,0,1,2'd2,0,0,0));
    tick();
    pmem_resp = 0; hit = 1; hit_way = 2'd2;
    chk("dm_rehit", ex(1,1,2'd2,0,0,0,0,2'd0,1,1,0));
    tick();
    mem_write = 0; hit = 0;
    chk("dm_idle", ZERO);

    // Reset during FETCH, then a late pmem_resp.
    way_valid = 4'b1011; way_dirty = 4'b0000; lru_way = 2'd0; mem_read = 1;
    tick();
    tick();
    chk("rf_fetch", ex(0,0,2'd0,1,0,0,0,2'd2,0,0,0));
    rst = 1;
    tick();
    rst = 0; mem_read = 0;
    chk("rf_after_rst", ZERO);
    pmem_resp = 1;
    chk("rf_late_resp", ZERO);
    tick();
    chk("rf_late_resp2", ZERO);
    pmem_resp = 0;

    // Full clean set picks LRU way 1; request dropped during FETCH.
    way_valid = 4'b1111; way_dirty = 4'b0000; lru_way = 2'd1; mem_read = 1;
    tick();
    tick();
    chk("ab_fetch", ex(0,0,2'd0,1,0,0,0,2'd1,0,0,0));
    mem_read = 0;
    chk("ab_fetch_drop", ex(0,0,2'd0,1,0,0,0,2'd1,0,0,0));
    tick();
    pmem_resp = 1;
    chk("ab_fill", ex(0,0,2'd0,1,0,0,1,2'd1,0,0,0));
    tick();
    pmem_resp = 0; hit = 1; hit_way = 2'd1;
    chk("ab_check_silent", ZERO);
    tick();
    hit = 0;
    chk("ab_idle", ZERO);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
